// File: rtl/plic_hart_claim_ctrl.sv
// Per-hart claim/complete controller at the output of the PLIC arbitration tree.
// Optional `PLIC_CMPLT_CHECK_EN`: only forward completes that match the last claimed ID.
module plic_hart_claim_ctrl #(
    parameter int ID_NUM     = 7,
    parameter int PRIO_BIT   = 6,
    parameter int SETTLE_CYC = 2
) (
    input  logic                plic_clk,
    input  logic                plicrst_b,
    input  logic                arb_int_req,
    input  logic [ID_NUM-1:0]   arb_int_id,
    input  logic [PRIO_BIT-1:0] arb_int_prio,
    input  logic                thresh_wr_vld,
    input  logic [PRIO_BIT-1:0] thresh_wr_data,
    output logic [PRIO_BIT-1:0] thresh_val,
    input  logic                claim_rd_vld,
    output logic                claim_rsp_vld,
    output logic [ID_NUM-1:0]   claim_rsp_id,
    output logic                pend_clr_vld,
    output logic [ID_NUM-1:0]   pend_clr_id,
    input  logic                cmplt_wr_vld,
    input  logic [ID_NUM-1:0]   cmplt_wr_id,
    output logic                cmplt_vld,
    output logic [ID_NUM-1:0]   cmplt_id,
    output logic                cmplt_err,
    output logic                hart_eip
);

    typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                win_req_q;
    logic [ID_NUM-1:0]   win_id_q;
    logic [PRIO_BIT-1:0] win_prio_q;
    logic [PRIO_BIT-1:0] thresh_q;
    logic                rsp_vld_q, rsp_vld_d;
    logic [ID_NUM-1:0]   rsp_id_q, rsp_id_d;
    logic                pend_vld_q, pend_vld_d;
    logic [ID_NUM-1:0]   pend_id_q, pend_id_d;
    logic                cmplt_vld_q, cmplt_vld_d;
    logic [ID_NUM-1:0]   cmplt_id_q, cmplt_id_d;
    logic                cmplt_err_q, cmplt_err_d;
    logic                qualified;
    logic                claim_ok;

    // Strict compare keeps prio 0 from ever interrupting, even at threshold 0.
    assign qualified = win_req_q && (win_prio_q > thresh_q) && (win_id_q != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_vld_d  = claim_rd_vld;
        rsp_id_d   = rsp_id_q;
        pend_vld_d = 1'b0;
        pend_id_d  = pend_id_q;
        claim_ok   = 1'b0;
        case (state_q)
            IDLE: begin
                if (claim_rd_vld) begin
                    if (qualified) begin
                        claim_ok   = 1'b1;
                        rsp_id_d   = win_id_q;
                        pend_vld_d = 1'b1;
                        pend_id_d  = win_id_q;
                        state_d    = SETTLE;
                        cnt_d      = 3'(SETTLE_CYC);
                    end else begin
                        rsp_id_d = '0;
                    end
                end
            end
            SETTLE: begin
                if (claim_rd_vld) rsp_id_d = '0;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

`ifdef PLIC_CMPLT_CHECK_EN
    logic [ID_NUM-1:0] claimed_q, claimed_d;
    logic              cmplt_match;

    // The complete is matched against the pre-claim value; a same-cycle claim then overwrites.
    assign cmplt_match = cmplt_wr_vld && (cmplt_wr_id != '0) && (cmplt_wr_id == claimed_q);

    always_comb begin
        claimed_d   = claimed_q;
        cmplt_vld_d = cmplt_match;
        cmplt_err_d = cmplt_wr_vld && !cmplt_match;
        cmplt_id_d  = cmplt_id_q;
        if (cmplt_match) begin
            claimed_d  = '0;
            cmplt_id_d = cmplt_wr_id;
        end
        if (claim_ok) claimed_d = win_id_q;
    end

    always_ff @(posedge plic_clk or negedge plicrst_b) begin
        if (!plicrst_b) claimed_q <= '0;
        else            claimed_q <= claimed_d;
    end
`else
    always_comb begin
        cmplt_vld_d = cmplt_wr_vld && (cmplt_wr_id != '0);
        cmplt_err_d = 1'b0;
        cmplt_id_d  = cmplt_vld_d ? cmplt_wr_id : cmplt_id_q;
    end
`endif

    always_ff @(posedge plic_clk or negedge plicrst_b) begin
        if (!plicrst_b) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            win_req_q   <= 1'b0;
            win_id_q    <= '0;
            win_prio_q  <= '0;
            thresh_q    <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_id_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_id_q   <= '0;
            cmplt_vld_q <= 1'b0;
            cmplt_id_q  <= '0;
            cmplt_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_req_q   <= arb_int_req;
            win_id_q    <= arb_int_id;
            win_prio_q  <= arb_int_prio;
            if (thresh_wr_vld) thresh_q <= thresh_wr_data;
            rsp_vld_q   <= rsp_vld_d;
            rsp_id_q    <= rsp_id_d;
            pend_vld_q  <= pend_vld_d;
            pend_id_q   <= pend_id_d;
            cmplt_vld_q <= cmplt_vld_d;
            cmplt_id_q  <= cmplt_id_d;
            cmplt_err_q <= cmplt_err_d;
        end
    end

    assign thresh_val    = thresh_q;
    assign claim_rsp_vld = rsp_vld_q;
    assign claim_rsp_id  = rsp_id_q;
    assign pend_clr_vld  = pend_vld_q;
    assign pend_clr_id   = pend_id_q;
    assign cmplt_vld     = cmplt_vld_q;
    assign cmplt_id      = cmplt_id_q;
    assign cmplt_err     = cmplt_err_q;
    assign hart_eip      = qualified && (state_q == IDLE);

endmodule

// File: tb/tb_plic_hart_claim_ctrl.sv
// Directed bench for plic_hart_claim_ctrl: threshold, claim/settle, complete, reset.
module tb_plic_hart_claim_ctrl;

    localparam int ID_NUM   = 7;
    localparam int PRIO_BIT = 6;

    logic                plic_clk = 1'b0;
    logic                plicrst_b = 1'b0;
    logic                arb_int_req = 1'b0;
    logic [ID_NUM-1:0]   arb_int_id = '0;
    logic [PRIO_BIT-1:0] arb_int_prio = '0;
    logic                thresh_wr_vld = 1'b0;
    logic [PRIO_BIT-1:0] thresh_wr_data = '0;
    logic [PRIO_BIT-1:0] thresh_val;
    logic                claim_rd_vld = 1'b0;
    logic                claim_rsp_vld;
    logic [ID_NUM-1:0]   claim_rsp_id;
    logic                pend_clr_vld;
    logic [ID_NUM-1:0]   pend_clr_id;
    logic                cmplt_wr_vld = 1'b0;
    logic [ID_NUM-1:0]   cmplt_wr_id = '0;
    logic                cmplt_vld;
    logic [ID_NUM-1:0]   cmplt_id;
    logic                cmplt_err;
    logic                hart_eip;

    int checks = 0;
    int failures = 0;

    plic_hart_claim_ctrl #(.ID_NUM(ID_NUM), .PRIO_BIT(PRIO_BIT), .SETTLE_CYC(2)) dut (
        .plic_clk(plic_clk), .plicrst_b(plicrst_b),
        .arb_int_req(arb_int_req), .arb_int_id(arb_int_id), .arb_int_prio(arb_int_prio),
        .thresh_wr_vld(thresh_wr_vld), .thresh_wr_data(thresh_wr_data), .thresh_val(thresh_val),
        .claim_rd_vld(claim_rd_vld), .claim_rsp_vld(claim_rsp_vld), .claim_rsp_id(claim_rsp_id),
        .pend_clr_vld(pend_clr_vld), .pend_clr_id(pend_clr_id),
        .cmplt_wr_vld(cmplt_wr_vld), .cmplt_wr_id(cmplt_wr_id),
        .cmplt_vld(cmplt_vld), .cmplt_id(cmplt_id), .cmplt_err(cmplt_err),
        .hart_eip(hart_eip)
    );

    always #5 plic_clk = ~plic_clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge plic_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL reset_eip: got %0b want 0", hart_eip); end
        checks++; if (thresh_val !== 6'd0) begin failures++; $display("FAIL reset_thresh: got %0d want 0", thresh_val); end
        checks++; if ({claim_rsp_vld, pend_clr_vld, cmplt_vld, cmplt_err} !== 4'b0) begin
            failures++; $display("FAIL reset_pulses: got %b want 0000", {claim_rsp_vld, pend_clr_vld, cmplt_vld, cmplt_err}); end
        checks++; if ({claim_rsp_id, pend_clr_id, cmplt_id} !== 21'd0) begin
            failures++; $display("FAIL reset_ids: got %h want 0", {claim_rsp_id, pend_clr_id, cmplt_id}); end
        @(negedge plic_clk);
        plicrst_b = 1'b1;
        step(1);
    endtask

    task automatic test_threshold();
        thresh_wr_vld = 1'b1; thresh_wr_data = 6'd2;
        step(1);
        thresh_wr_vld = 1'b0;
        checks++; if (thresh_val !== 6'd2) begin failures++; $display("FAIL thresh_load: got %0d want 2", thresh_val); end
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL eip_no_req: got %0b want 0", hart_eip); end
        arb_int_req = 1'b1; arb_int_id = 7'd5; arb_int_prio = 6'd3;
        step(1);
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL eip_prio3_th2: got %0b want 1", hart_eip); end
        thresh_wr_vld = 1'b1; thresh_wr_data = 6'd3;
        step(1);
        thresh_wr_vld = 1'b0;
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL eip_prio_eq_thresh: got %0b want 0", hart_eip); end
        thresh_wr_vld = 1'b1; thresh_wr_data = 6'd0;
        step(1);
        thresh_wr_vld = 1'b0;
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL eip_th0: got %0b want 1", hart_eip); end
        arb_int_id = 7'd0;
        step(1);
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL eip_id0: got %0b want 0", hart_eip); end
    endtask

    task automatic test_claim();
        arb_int_req = 1'b1; arb_int_id = 7'd9; arb_int_prio = 6'd5;
        step(1);
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL claim_pre_eip: got %0b want 1", hart_eip); end
        claim_rd_vld = 1'b1;
        step(1);
        claim_rd_vld = 1'b0;
        checks++; if ({claim_rsp_vld, claim_rsp_id} !== {1'b1, 7'd9}) begin
            failures++; $display("FAIL claim_rsp: got vld=%0b id=%0d want vld=1 id=9", claim_rsp_vld, claim_rsp_id); end
        checks++; if ({pend_clr_vld, pend_clr_id} !== {1'b1, 7'd9}) begin
            failures++; $display("FAIL claim_pend: got vld=%0b id=%0d want vld=1 id=9", pend_clr_vld, pend_clr_id); end
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL settle_eip1: got %0b want 0", hart_eip); end
        step(1);
        checks++; if ({claim_rsp_vld, pend_clr_vld, hart_eip} !== 3'b000) begin
            failures++; $display("FAIL settle_cyc2: got rsp=%0b pend=%0b eip=%0b want 0 0 0", claim_rsp_vld, pend_clr_vld, hart_eip); end
        checks++; if (claim_rsp_id !== 7'd9) begin failures++; $display("FAIL rsp_id_hold: got %0d want 9", claim_rsp_id); end
        step(1);
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL settle_exit_eip: got %0b want 1", hart_eip); end
    endtask

    task automatic test_no_qual();
        arb_int_prio = 6'd0;
        step(1);
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL prio0_eip: got %0b want 0", hart_eip); end
        claim_rd_vld = 1'b1;
        step(1);
        claim_rd_vld = 1'b0;
        checks++; if ({claim_rsp_vld, claim_rsp_id, pend_clr_vld} !== {1'b1, 7'd0, 1'b0}) begin
            failures++; $display("FAIL noqual_rsp: got vld=%0b id=%0d pend=%0b want 1 0 0", claim_rsp_vld, claim_rsp_id, pend_clr_vld); end
        arb_int_prio = 6'd5;
        step(1);
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL noqual_stays_idle: got %0b want 1", hart_eip); end
    endtask

    task automatic test_back_to_back();
        claim_rd_vld = 1'b1;
        step(1);
        checks++; if ({claim_rsp_vld, claim_rsp_id, pend_clr_vld} !== {1'b1, 7'd9, 1'b1}) begin
            failures++; $display("FAIL b2b_first: got vld=%0b id=%0d pend=%0b want 1 9 1", claim_rsp_vld, claim_rsp_id, pend_clr_vld); end
        step(1);
        claim_rd_vld = 1'b0;
        checks++; if ({claim_rsp_vld, claim_rsp_id, pend_clr_vld} !== {1'b1, 7'd0, 1'b0}) begin
            failures++; $display("FAIL b2b_settle_claim: got vld=%0b id=%0d pend=%0b want 1 0 0", claim_rsp_vld, claim_rsp_id, pend_clr_vld); end
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL b2b_settle_eip: got %0b want 0", hart_eip); end
        step(1);
        checks++; if ({claim_rsp_vld, hart_eip} !== 2'b01) begin
            failures++; $display("FAIL b2b_counter_kept: got rsp=%0b eip=%0b want 0 1", claim_rsp_vld, hart_eip); end
    endtask

`ifndef PLIC_CMPLT_CHECK_EN
    task automatic test_complete();
        cmplt_wr_vld = 1'b1; cmplt_wr_id = 7'd9;
        step(1);
        checks++; if ({cmplt_vld, cmplt_id, cmplt_err} !== {1'b1, 7'd9, 1'b0}) begin
            failures++; $display("FAIL cmplt9: got vld=%0b id=%0d err=%0b want 1 9 0", cmplt_vld, cmplt_id, cmplt_err); end
        cmplt_wr_id = 7'd0;
        step(1);
        checks++; if ({cmplt_vld, cmplt_err} !== 2'b00) begin
            failures++; $display("FAIL cmplt0_drop: got vld=%0b err=%0b want 0 0", cmplt_vld, cmplt_err); end
        cmplt_wr_id = 7'd3;
        step(1);
        checks++; if ({cmplt_vld, cmplt_id} !== {1'b1, 7'd3}) begin
            failures++; $display("FAIL cmplt_b2b_a: got vld=%0b id=%0d want 1 3", cmplt_vld, cmplt_id); end
        cmplt_wr_id = 7'd5; claim_rd_vld = 1'b1;
        step(1);
        cmplt_wr_vld = 1'b0; claim_rd_vld = 1'b0;
        checks++; if ({cmplt_vld, cmplt_id} !== {1'b1, 7'd5}) begin
            failures++; $display("FAIL cmplt_b2b_b: got vld=%0b id=%0d want 1 5", cmplt_vld, cmplt_id); end
        checks++; if ({claim_rsp_vld, claim_rsp_id} !== {1'b1, 7'd9}) begin
            failures++; $display("FAIL claim_with_cmplt: got vld=%0b id=%0d want 1 9", claim_rsp_vld, claim_rsp_id); end
        step(1);
        checks++; if (cmplt_vld !== 1'b0) begin failures++; $display("FAIL cmplt_one_cycle: got %0b want 0", cmplt_vld); end
        step(2);
    endtask
`else
    task automatic test_cmplt_check();
        claim_rd_vld = 1'b1;
        step(1);
        claim_rd_vld = 1'b0;
        checks++; if (claim_rsp_id !== 7'd9) begin failures++; $display("FAIL chk_claim: got %0d want 9", claim_rsp_id); end
        cmplt_wr_vld = 1'b1; cmplt_wr_id = 7'd4;
        step(1);
        checks++; if ({cmplt_vld, cmplt_err} !== 2'b01) begin
            failures++; $display("FAIL chk_mismatch: got vld=%0b err=%0b want 0 1", cmplt_vld, cmplt_err); end
        cmplt_wr_id = 7'd9;
        step(1);
        checks++; if ({cmplt_vld, cmplt_id, cmplt_err} !== {1'b1, 7'd9, 1'b0}) begin
            failures++; $display("FAIL chk_match: got vld=%0b id=%0d err=%0b want 1 9 0", cmplt_vld, cmplt_id, cmplt_err); end
        step(1);
        cmplt_wr_vld = 1'b0;
        checks++; if ({cmplt_vld, cmplt_err} !== 2'b01) begin
            failures++; $display("FAIL chk_repeat: got vld=%0b err=%0b want 0 1", cmplt_vld, cmplt_err); end
        step(1);
        claim_rd_vld = 1'b1;
        step(1);
        claim_rd_vld = 1'b0;
        step(2);
        claim_rd_vld = 1'b1; cmplt_wr_vld = 1'b1; cmplt_wr_id = 7'd9;
        step(1);
        claim_rd_vld = 1'b0;
        checks++; if ({cmplt_vld, cmplt_err, claim_rsp_id} !== {2'b10, 7'd9}) begin
            failures++; $display("FAIL chk_same_cycle: got vld=%0b err=%0b rsp=%0d want 1 0 9", cmplt_vld, cmplt_err, claim_rsp_id); end
        step(1);
        cmplt_wr_vld = 1'b0;
        checks++; if ({cmplt_vld, cmplt_err} !== 2'b10) begin
            failures++; $display("FAIL chk_new_claim_loaded: got vld=%0b err=%0b want 1 0", cmplt_vld, cmplt_err); end
        step(2);
    endtask
`endif

    task automatic test_reset_mid_settle();
        thresh_wr_vld = 1'b1; thresh_wr_data = 6'd1;
        step(1);
        thresh_wr_vld = 1'b0;
        claim_rd_vld = 1'b1; cmplt_wr_vld = 1'b1; cmplt_wr_id = 7'd9;
        step(1);
        claim_rd_vld = 1'b0; cmplt_wr_vld = 1'b0;
        checks++; if ({claim_rsp_vld, pend_clr_vld} !== 2'b11) begin
            failures++; $display("FAIL rst_pre_pulses: got rsp=%0b pend=%0b want 1 1", claim_rsp_vld, pend_clr_vld); end
        #2 plicrst_b = 1'b0;
        #1;
        checks++; if ({claim_rsp_vld, pend_clr_vld, cmplt_vld, cmplt_err, hart_eip} !== 5'b0) begin
            failures++; $display("FAIL rst_async_pulses: got %b want 00000", {claim_rsp_vld, pend_clr_vld, cmplt_vld, cmplt_err, hart_eip}); end
        checks++; if ({thresh_val, claim_rsp_id, pend_clr_id, cmplt_id} !== 27'd0) begin
            failures++; $display("FAIL rst_async_regs: got %h want 0", {thresh_val, claim_rsp_id, pend_clr_id, cmplt_id}); end
        #1 plicrst_b = 1'b1;
        #1;
        checks++; if (hart_eip !== 1'b0) begin failures++; $display("FAIL rst_release_eip: got %0b want 0", hart_eip); end
        step(1);
        checks++; if (hart_eip !== 1'b1) begin failures++; $display("FAIL rst_idle_eip: got %0b want 1", hart_eip); end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_claim();
        test_no_qual();
        test_back_to_back();
`ifndef PLIC_CMPLT_CHECK_EN
        test_complete();
`else
        test_cmplt_check();
`endif
        test_reset_mid_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
